// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request bus between the three drawing requesters and the plot arbiter,
// including the registered pixel stream that feeds vga_adapter.
interface vga_plot_arbiter_if;
    logic [2:0] req;
    logic [2:0] last;
    logic [8:0] colour_0;
    logic [8:0] colour_1;
    logic [8:0] colour_2;
    logic [7:0] x_0;
    logic [7:0] x_1;
    logic [7:0] x_2;
    logic [6:0] y_0;
    logic [6:0] y_1;
    logic [6:0] y_2;
    logic [2:0] gnt;
    logic [2:0] accept;
    logic [8:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic       busy;

    modport master (
        output req, last, colour_0, colour_1, colour_2, x_0, x_1, x_2, y_0, y_1, y_2,
        input  gnt, accept, colour, x, y, plot, busy
    );

    modport slave (
        input  req, last, colour_0, colour_1, colour_2, x_0, x_1, x_2, y_0, y_1, y_2,
        output gnt, accept, colour, x, y, plot, busy
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one vga_adapter write port between three pixel
// requesters, with bounded bursts and optional transparent-colour skipping.
module vga_plot_arbiter #(
    parameter int unsigned MAX_BURST   = 64,
    parameter logic [8:0]  TRANSPARENT = 9'h1FF,
    parameter bit          TRANSP_EN   = 1'b1
) (
    input logic             clk,
    input logic             resetn,
    vga_plot_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [8:0] colour_q, colour_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       plot_q, plot_d;

    logic [2:0] accept;
    logic [2:0] rr_gnt;
    logic [8:0] sel_colour;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic       any_accept;
    logic       last_accept;
    logic       transparent;

    assign accept      = gnt_q & bus.req;
    assign any_accept  = |accept;
    assign last_accept = |(accept & bus.last);

    // gnt_q is one-hot in StOwn, so an AND-OR mux picks the owner's pixel.
    assign sel_colour = ({9{gnt_q[0]}} & bus.colour_0) | ({9{gnt_q[1]}} & bus.colour_1) |
                        ({9{gnt_q[2]}} & bus.colour_2);
    assign sel_x      = ({8{gnt_q[0]}} & bus.x_0) | ({8{gnt_q[1]}} & bus.x_1) |
                        ({8{gnt_q[2]}} & bus.x_2);
    assign sel_y      = ({7{gnt_q[0]}} & bus.y_0) | ({7{gnt_q[1]}} & bus.y_1) |
                        ({7{gnt_q[2]}} & bus.y_2);

    assign transparent = TRANSP_EN && (sel_colour == TRANSPARENT);

    // Search order starts just after the previous owner.
    always_comb begin
        rr_gnt = 3'b000;
        case (last_owner_q)
            2'd0: begin
                if      (bus.req[1]) rr_gnt = 3'b010;
                else if (bus.req[2]) rr_gnt = 3'b100;
                else if (bus.req[0]) rr_gnt = 3'b001;
            end
            2'd1: begin
                if      (bus.req[2]) rr_gnt = 3'b100;
                else if (bus.req[0]) rr_gnt = 3'b001;
                else if (bus.req[1]) rr_gnt = 3'b010;
            end
            default: begin
                if      (bus.req[0]) rr_gnt = 3'b001;
                else if (bus.req[1]) rr_gnt = 3'b010;
                else if (bus.req[2]) rr_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        colour_d     = colour_q;
        x_d          = x_q;
        y_d          = y_q;
        plot_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gnt_d       = rr_gnt;
                    burst_cnt_d = 8'd0;
                    state_d     = StOwn;
                end
            end
            StOwn: begin
                if (any_accept) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (!transparent) begin
                        colour_d = sel_colour;
                        x_d      = sel_x;
                        y_d      = sel_y;
                        plot_d   = 1'b1;
                    end
                end
                // Any combination of release causes collapses into one release.
                if (!any_accept || last_accept || (burst_cnt_q == BurstLast)) begin
                    state_d      = StIdle;
                    gnt_d        = 3'b000;
                    last_owner_d = {gnt_q[2], gnt_q[1]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            gnt_q        <= 3'b000;
            last_owner_q <= 2'd2;
            burst_cnt_q  <= 8'd0;
            colour_q     <= 9'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            colour_q     <= colour_d;
            x_q          <= x_d;
            y_q          <= y_d;
            plot_q       <= plot_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.accept = accept;
    assign bus.colour = colour_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = (state_q == StOwn);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: two instances (MAX_BURST 64 and 2) share one
// stimulus stream and are compared against a transaction-level model each cycle.
module tb_vga_plot_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    vga_plot_arbiter_if ifa ();
    vga_plot_arbiter_if ifb ();

    vga_plot_arbiter dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
    vga_plot_arbiter #(.MAX_BURST(2)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

    logic [2:0] r, l;
    logic [8:0] pc [3];
    logic [7:0] px [3];
    logic [6:0] py [3];

    assign ifa.req = r;  assign ifa.last = l;
    assign ifa.colour_0 = pc[0]; assign ifa.colour_1 = pc[1]; assign ifa.colour_2 = pc[2];
    assign ifa.x_0 = px[0]; assign ifa.x_1 = px[1]; assign ifa.x_2 = px[2];
    assign ifa.y_0 = py[0]; assign ifa.y_1 = py[1]; assign ifa.y_2 = py[2];
    assign ifb.req = r;  assign ifb.last = l;
    assign ifb.colour_0 = pc[0]; assign ifb.colour_1 = pc[1]; assign ifb.colour_2 = pc[2];
    assign ifb.x_0 = px[0]; assign ifb.x_1 = px[1]; assign ifb.x_2 = px[2];
    assign ifb.y_0 = py[0]; assign ifb.y_1 = py[1]; assign ifb.y_2 = py[2];

    logic [2:0] o_gnt [2];
    logic [2:0] o_acc [2];
    logic [8:0] o_col [2];
    logic [7:0] o_x [2];
    logic [6:0] o_y [2];
    logic       o_plot [2];
    logic       o_busy [2];

    assign o_gnt[0] = ifa.gnt;    assign o_gnt[1] = ifb.gnt;
    assign o_acc[0] = ifa.accept; assign o_acc[1] = ifb.accept;
    assign o_col[0] = ifa.colour; assign o_col[1] = ifb.colour;
    assign o_x[0] = ifa.x;        assign o_x[1] = ifb.x;
    assign o_y[0] = ifa.y;        assign o_y[1] = ifb.y;
    assign o_plot[0] = ifa.plot;  assign o_plot[1] = ifb.plot;
    assign o_busy[0] = ifa.busy;  assign o_busy[1] = ifb.busy;

    int checks = 0;
    int failures = 0;

    // Reference model: owner index (-1 when nobody owns the bus) plus pixel output state.
    int         maxb [2] = '{64, 2};
    int         m_own [2];
    int         m_cnt [2];
    int         m_lown [2];
    logic       m_plot [2];
    logic [8:0] m_col [2];
    logic [7:0] m_x [2];
    logic [6:0] m_y [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input int o);
        return (o < 0) ? 3'b000 : 3'(1 << o);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_cnt[i] = 0; m_lown[i] = 2; m_plot[i] = 1'b0;
            m_col[i] = '0; m_x[i] = '0; m_y[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        int  o;
        bit  found;
        m_plot[i] = 1'b0;
        if (m_own[i] < 0) begin
            if (r != 3'b000) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    o = (m_lown[i] + k) % 3;
                    if (!found && r[o]) begin
                        m_own[i] = o;
                        found = 1'b1;
                    end
                end
                m_cnt[i] = 0;
            end
        end else begin
            o = m_own[i];
            if (r[o]) begin
                if (pc[o] != 9'h1FF) begin
                    m_col[i] = pc[o]; m_x[i] = px[o]; m_y[i] = py[o]; m_plot[i] = 1'b1;
                end
                if (l[o] || m_cnt[i] == maxb[i] - 1) begin
                    m_lown[i] = o; m_own[i] = -1;
                end
                m_cnt[i]++;
            end else begin
                m_lown[i] = o; m_own[i] = -1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("gnt%0d", i), 32'(o_gnt[i]), 32'(onehot(m_own[i])));
            check($sformatf("plot%0d", i), 32'(o_plot[i]), 32'(m_plot[i]));
            check($sformatf("colour%0d", i), 32'(o_col[i]), 32'(m_col[i]));
            check($sformatf("x%0d", i), 32'(o_x[i]), 32'(m_x[i]));
            check($sformatf("y%0d", i), 32'(o_y[i]), 32'(m_y[i]));
            check($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_own[i] >= 0));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("accept%0d", i), 32'(o_acc[i]), 32'(r & onehot(m_own[i])));
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_pix();
        for (int k = 0; k < 3; k++) begin
            pc[k] = ($urandom % 4 == 0) ? 9'h1FF : 9'($urandom);
            px[k] = 8'($urandom);
            py[k] = 7'($urandom);
        end
    endtask

    int np;

    initial begin
        resetn = 1'b0; r = 3'b000; l = 3'b000;
        rand_pix();
        model_reset();
        #12;
        check_outputs();
        @(posedge clk); #1;
        resetn = 1'b1;

        // All three requesting continuously: 64-pixel grants rotating 0,1,2 with one bubble.
        r = 3'b111; l = 3'b000;
        for (int t = 1; t <= 200; t++) begin
            rand_pix();
            cycle();
            check("rr_seq", 32'(ifa.gnt),
                  32'(((t - 1) % 65 == 64) ? 3'b000 : onehot(((t - 1) / 65) % 3)));
        end
        r = 3'b000;
        repeat (3) cycle();

        // Single pixel from requester 1 with last set.
        r = 3'b010; l = 3'b010; pc[1] = 9'h0E0; px[1] = 8'd10; py[1] = 7'd20;
        cycle();
        check("single_gnt", 32'(ifa.gnt), 32'(3'b010));
        cycle();
        check("single_x", 32'(ifa.x), 32'd10);
        check("single_y", 32'(ifa.y), 32'd20);
        check("single_col", 32'(ifa.colour), 32'h0E0);
        check("single_plot", 32'(ifa.plot), 32'd1);
        check("single_busy", 32'(ifa.busy), 32'd0);
        r = 3'b000; l = 3'b000;
        cycle();

        // Transparent then opaque pixel from requester 2.
        r = 3'b100; pc[2] = 9'h1FF; px[2] = 8'd77; py[2] = 7'd33;
        cycle();
        cycle();
        check("transp_plot", 32'(ifa.plot), 32'd0);
        check("transp_x", 32'(ifa.x), 32'd10);
        check("transp_y", 32'(ifa.y), 32'd20);
        pc[2] = 9'h007; px[2] = 8'd5; py[2] = 7'd6; l = 3'b100;
        cycle();
        check("opaque_plot", 32'(ifa.plot), 32'd1);
        check("opaque_col", 32'(ifa.colour), 32'h007);
        r = 3'b000; l = 3'b000;
        repeat (2) cycle();

        // Requester 0 drops req after five pixels; requester 1 takes over after a bubble.
        r = 3'b011; pc[0] = 9'h011; pc[1] = 9'h022;
        np = 0;
        cycle();
        check("drop_gnt0", 32'(ifa.gnt), 32'(3'b001));
        repeat (5) begin
            cycle();
            np += int'(ifa.plot);
        end
        r = 3'b010;
        cycle();
        np += int'(ifa.plot);
        check("drop_release", 32'(ifa.gnt), 32'(3'b000));
        cycle();
        np += int'(ifa.plot);
        check("drop_gnt1", 32'(ifa.gnt), 32'(3'b010));
        check("drop_plots", 32'(np), 32'd5);
        r = 3'b000;
        repeat (3) cycle();

        // Random traffic.
        repeat (400) begin
            r = 3'($urandom_range(0, 7));
            l = {3'($urandom % 8 == 0), 3'($urandom % 8 == 0), 3'($urandom % 8 == 0)} == 9'd0 ?
                3'b000 : {1'($urandom % 8 == 0), 1'($urandom % 8 == 0), 1'($urandom % 8 == 0)};
            rand_pix();
            cycle();
        end
        r = 3'b000; l = 3'b000;
        repeat (3) cycle();

        // Asynchronous reset in the middle of a requester-1 burst.
        r = 3'b010; pc[1] = 9'h055;
        repeat (4) cycle();
        resetn = 1'b0; r = 3'b111;
        #2;
        check("rst_gnt_a", 32'(ifa.gnt), 32'd0);
        check("rst_plot_a", 32'(ifa.plot), 32'd0);
        check("rst_busy_a", 32'(ifa.busy), 32'd0);
        check("rst_gnt_b", 32'(ifb.gnt), 32'd0);
        model_reset();
        #1;
        resetn = 1'b1;
        cycle();
        check("post_rst_gnt_a", 32'(ifa.gnt), 32'(3'b001));
        check("post_rst_gnt_b", 32'(ifb.gnt), 32'(3'b001));
        r = 3'b000;
        repeat (3) cycle();

        // MAX_BURST = 2 instance: two accepts, one bubble, regrant to 0.
        r = 3'b001; l = 3'b000; pc[0] = 9'h0AA;
        for (int t = 1; t <= 12; t++) begin
            cycle();
            check("burst2", 32'(ifb.gnt), 32'(((t - 1) % 3 == 2) ? 3'b000 : 3'b001));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64, means the maximum pixels accepted per grant before forced release; legal range 2..255.
REQ-002 Parameter TRANSPARENT, default 9'h1FF, is the colour value that is accepted but never plotted.
REQ-003 Parameter TRANSP_EN, default 1, enables transparency skipping when 1.
REQ-004 Port clk, input, 1 bit: the single clock, CLOCK_50 domain.
REQ-005 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port req, input, 3 bits: per-requester pixel valid (0 = background restore, 1 = tower drawer, 2 = car drawer).
REQ-007 Port last, input, 3 bits: per-requester flag marking its current pixel as the final pixel of its burst.
REQ-008 Ports colour_0, colour_1 and colour_2, inputs, 9 bits each: the requester pixel colours.
REQ-009 Ports x_0, x_1 and x_2, inputs, 8 bits each: the requester pixel x coordinates.
REQ-010 Ports y_0, y_1 and y_2, inputs, 7 bits each: the requester pixel y coordinates.
REQ-011 Port gnt, output, 3 bits: registered one-hot owner; all zero when idle.
REQ-012 Port accept, output, 3 bits: combinational gnt & req, marking the pixel consumed this cycle.
REQ-013 Port colour, output, 9 bits: registered colour to vga_adapter.
REQ-014 Port x, output, 8 bits: registered x to vga_adapter.
REQ-015 Port y, output, 7 bits: registered y to vga_adapter.
REQ-016 Port plot, output, 1 bit: registered write enable to vga_adapter.
REQ-017 Port busy, output, 1 bit: high while in state OWN.

Function
REQ-018 The FSM shall have two states, IDLE and OWN, with gnt nonzero only in OWN.
REQ-019 In IDLE with any req bit high, the block shall select a winner by round-robin starting at (last_owner+1) mod 3, load gnt one-hot, clear burst_cnt and enter OWN on the next edge.
REQ-020 In IDLE with req == 0, the block shall stay in IDLE with gnt = 0.
REQ-021 In OWN, each cycle with accept[i] = 1 shall register colour_i, x_i and y_i to the outputs and increment the 8-bit burst_cnt.
REQ-022 plot shall be 1 the cycle after an accept, with fixed 1-cycle latency, unless TRANSP_EN = 1 and the accepted colour equals TRANSPARENT.
REQ-023 For a transparent pixel, plot shall be 0 and colour, x and y shall hold their previous values.
REQ-024 In OWN, the block shall release (next state IDLE, gnt = 0, last_owner = owner) on any of: an accept with last[i] = 1; an accept when burst_cnt == MAX_BURST-1; or req[i] = 0.
REQ-025 Every release shall cost exactly one IDLE bubble cycle, so back-to-back owners are separated by one cycle with gnt = 0.
REQ-026 When simultaneous release conditions occur, the outcome shall be identical: a single release, and the pixel, if accepted, shall be plotted.
REQ-027 The req, last and pixel inputs of non-owners shall be ignored; a non-owner's accept bit shall be 0.
REQ-028 A forced release by MAX_BURST shall not drop pixels: the requester keeps req high and re-arbitrates, and its remaining pixels follow when it is next granted.
REQ-029 burst_cnt shall not wrap, because release occurs at MAX_BURST-1.
REQ-030 plot shall be 0 in every cycle not immediately following an accept.

Reset
REQ-031 When resetn is low, asynchronously and regardless of clk: state = IDLE, gnt = 0, burst_cnt = 0, last_owner = 2 (so requester 0 wins first), colour = 0, x = 0, y = 0, plot = 0, busy = 0.
REQ-032 Reset asserted mid-burst shall abort the burst with no further plot; after release, arbitration restarts per REQ-019.

Verification
REQ-033 Scenario: reset release, then req = 3'b111 held with last = 0 -> gnt sequence 001, 010, 100, 001, each grant lasting 64 accepts, separated by one gnt = 0 cycle.
REQ-034 Scenario: only req[1], pixel (x = 10, y = 20, colour = 9'h0E0), last = 1 -> gnt = 010 for one cycle, then x = 10, y = 20, colour = 9'h0E0, plot = 1 one cycle later, then busy = 0.
REQ-035 Scenario: owner 2 sends colour 9'h1FF then 9'h007 -> plot 0 then 1, with x and y unchanged during the transparent cycle.
REQ-036 Scenario: owner 0 drops req after 5 accepts -> exactly 5 plot pulses, gnt = 0 next cycle, requester 1 granted if pending.
REQ-037 Scenario: resetn pulsed low while owner 1 is mid-burst -> plot = 0 and gnt = 0 immediately; the first post-reset grant goes to requester 0 if requesting.
REQ-038 Scenario: MAX_BURST = 2, req[0] only with last = 0 -> repeating pattern: 2 accepts, 1 idle cycle, regrant to 0.
